risc_loader: RTL and testbench

RISC_LOADER -- requirements
Module: risc_loader

---
 rtl/risc_pkg.sv | 32 +++
 rtl/sat_counter.sv | 20 ++
 rtl/risc_loader.sv | 115 +++++++++++
 tb/tb_risc_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC loader: opcode set, memory geometry,
// image length limits and the loader state encoding.
package risc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CRST = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    // An image must hold at least one byte and fit in the core memory.
    function automatic logic len_valid(input logic [LEN_W-1:0] l);
        return (l != '0) && (l <= LEN_W'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its maximum value.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/risc_loader.sv
// Loads a byte image into the RISC core memory, releases the core from reset
// and supervises the run until halt or timeout.
module risc_loader
    import risc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [15:0]       cycles
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  len_q;
    logic              can_start;
    logic              start_ok;
    logic              xfer;
    logic              last_beat;
    logic              run_step;
    logic              hit_limit;

    assign can_start = start && ((state == S_IDLE) || (state == S_FIN));
    assign start_ok  = can_start && len_valid(len);
    assign xfer      = (state == S_LOAD) && in_valid;
    assign last_beat = xfer && ({1'b0, ptr} == (len_q - LEN_W'(1)));
    assign run_step  = (state == S_RUN) && !cpu_halt;
    // The run ends on the edge that brings cycles up to the limit.
    assign hit_limit = run_step && (({16'd0, cycles} + 32'd1) >= TIMEOUT_LIM);

    assign in_ready  = (state == S_LOAD);
    assign mem_we    = xfer;
    assign mem_addr  = ptr;
    assign mem_wdata = in_data;
    assign cpu_rst   = (state == S_IDLE) || (state == S_LOAD) || (state == S_CRST);
    assign busy      = (state == S_LOAD) || (state == S_CRST) || (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            len_q   <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (start_ok) begin
                        done    <= 1'b0;
                        timeout <= 1'b0;
                        err     <= 1'b0;
                        ptr     <= '0;
                        len_q   <= len;
                        state   <= S_LOAD;
                    end else if (can_start) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (last_beat) begin
                            state <= S_CRST;
                        end
                    end
                end
                S_CRST: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (hit_limit) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(16)
    ) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (run_step),
        .count (cycles)
    );

endmodule

// File: tb/tb_risc_loader.sv
// Scoreboard bench for risc_loader: a small behavioural RISC core executes the
// loaded image while monitors check every memory write and every session result.
module tb_risc_loader;
    import risc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              cpu_halt = 1'b0;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err;
    logic [15:0]       cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic        to;
    } result_t;

    logic [12:0]  wr_q [$];
    result_t      res_q [$];
    logic [7:0]   image [32];
    logic [7:0]   cmem [32];
    logic [4:0]   pc = '0;
    logic [2:0]   phase = '0;
    logic         done_d = 1'b0;
    logic         halt_seen = 1'b0;

    risc_loader #(
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err       (err),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    // Core model: eight clocks per instruction, HLT raises halt on its fourth clock.
    always @(posedge clk) begin
        if (mem_we) begin
            cmem[mem_addr] <= mem_wdata;
        end
        if (cpu_rst) begin
            pc       <= '0;
            phase    <= '0;
            cpu_halt <= 1'b0;
        end else if (!cpu_halt) begin
            if ((phase == 3'd3) && (cmem[pc][7:5] == HLT)) begin
                cpu_halt <= 1'b1;
            end else if (phase == 3'd7) begin
                phase <= '0;
                pc    <= (cmem[pc][7:5] == JMP) ? cmem[pc][4:0] : pc + 5'd1;
            end else begin
                phase <= phase + 3'd1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor and result monitor pop what the stimulus promised.
    always @(negedge clk) begin
        if (cpu_halt) begin
            halt_seen = 1'b1;
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0h expected none", mem_addr, mem_wdata);
            end else begin
                check_output("write", 32'({mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
            end
        end
        if (done && !done_d) begin
            if (res_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got cycles %0d expected no session end", cycles);
            end else begin
                result_t r;
                r = res_q.pop_front();
                check_output("cycles", 32'(cycles), 32'(r.cyc));
                check_output("timeout", 32'(timeout), 32'(r.to));
            end
        end
        done_d = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_busy"}, 32'(busy), 0);
        check_output({tag, "_done"}, 32'(done), 0);
        check_output({tag, "_timeout"}, 32'(timeout), 0);
        check_output({tag, "_err"}, 32'(err), 0);
        check_output({tag, "_in_ready"}, 32'(in_ready), 0);
        check_output({tag, "_mem_we"}, 32'(mem_we), 0);
        check_output({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
        check_output({tag, "_cycles"}, 32'(cycles), 0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && (n < limit)) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_done: got no done after %0d cycles expected done", limit);
        end
        step();
    endtask

    task automatic apply_stimulus(input int n, input bit bp, input logic [15:0] exp_cyc, input bit exp_to);
        res_q.push_back({exp_cyc, exp_to});
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bp) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = image[i];
            wr_q.push_back({5'(i), image[i]});
            step();
        end
        in_valid = 1'b1;
        in_data  = 8'hFF;
        check_output("crst_in_ready", 32'(in_ready), 0);
        check_output("crst_busy", 32'(busy), 1);
        check_output("crst_cpu_rst", 32'(cpu_rst), 1);
        step();
        in_valid = 1'b0;
        check_output("run_cpu_rst", 32'(cpu_rst), 0);
        wait_done(300);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        check_reset_state("por");
        rst = 1'b0;
        step();

        start = 1'b1;
        len   = 6'd33;
        step();
        start = 1'b0;
        check_output("len33_err", 32'(err), 1);
        step();
        check_output("len33_busy", 32'(busy), 0);
        check_output("len33_in_ready", 32'(in_ready), 0);
        check_output("len33_cpu_rst", 32'(cpu_rst), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rst_err", 32'(err), 0);
        start = 1'b1;
        len   = 6'd0;
        step();
        start = 1'b0;
        check_output("len0_err", 32'(err), 1);
        step();
        check_output("len0_busy", 32'(busy), 0);
        check_output("len0_cpu_rst", 32'(cpu_rst), 1);

        image[0] = {HLT, 5'd0};
        apply_stimulus(1, 1'b0, 16'd4, 1'b0);
        check_output("hlt_done", 32'(done), 1);
        check_output("hlt_err", 32'(err), 0);
        check_output("fin_cpu_rst", 32'(cpu_rst), 0);
        check_output("fin_busy", 32'(busy), 0);

        image[0] = {JMP, 5'd2};
        image[1] = {JMP, 5'd2};
        image[2] = {HLT, 5'd0};
        apply_stimulus(3, 1'b0, 16'd12, 1'b0);

        image[0] = {ADD, 5'd5};
        image[1] = {XOR, 5'd6};
        image[2] = {AND, 5'd7};
        image[3] = {HLT, 5'd0};
        image[4] = {SKZ, 5'd3};
        apply_stimulus(5, 1'b1, 16'd28, 1'b0);
        rst = 1'b1;
        step();
        check_reset_state("rst_fin");
        rst = 1'b0;
        step();

        image[0] = {JMP, 5'd0};
        halt_seen = 1'b0;
        apply_stimulus(1, 1'b0, 16'd50, 1'b1);
        check_output("to_halt_seen", 32'(halt_seen), 0);
        check_output("to_done", 32'(done), 1);
        check_output("to_timeout", 32'(timeout), 1);

        start = 1'b1;
        len   = 6'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            wr_q.push_back({5'(i), in_data});
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_reset_state("rst_load");
        rst = 1'b0;
        step();
        image[0] = {HLT, 5'd0};
        apply_stimulus(1, 1'b0, 16'd4, 1'b0);

        step();
        check_output("writes_left", 32'(wr_q.size()), 0);
        check_output("results_left", 32'(res_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
